// File: rtl/cpu_timer.sv
// 8051-style Timer0/Timer1 SFR responder: TCON/TMOD/TLx/THx registers, shared
// clock prescaler, pin synchronisers and 13/16/8-bit-reload counting modes.
module cpu_timer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    PRESCALE   = 12,
  parameter logic [ADDR_WIDTH-1:0] TCON_ADDR  = 8'h88
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] MEM_WR_DATA,
  output logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic                  MEM_WR,
  input  logic                  MEM_RD,
  input  logic                  T0_IN,
  input  logic                  T1_IN,
  input  logic                  INT0_N,
  input  logic                  INT1_N,
  input  logic                  TF0_CLR,
  input  logic                  TF1_CLR,
  output logic                  TF0,
  output logic                  TF1
);

  localparam logic [ADDR_WIDTH-1:0] TMOD_ADDR = TCON_ADDR + ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TL0_ADDR  = TCON_ADDR + ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] TL1_ADDR  = TCON_ADDR + ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] TH0_ADDR  = TCON_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] TH1_ADDR  = TCON_ADDR + ADDR_WIDTH'(5);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  // Index 0 is Timer0, index 1 is Timer1 throughout.
  logic [1:0][DATA_WIDTH-1:0] tl_q, tl_d, th_q, th_d;
  logic [1:0]                 tr_q, tr_d, tf_q, tf_d;
  logic [DATA_WIDTH-1:0]      tmod_q, tmod_d;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [2:0]                 t0_sync_q, t0_sync_d, t1_sync_q, t1_sync_d;
  logic [1:0]                 int0_sync_q, int0_sync_d, int1_sync_q, int1_sync_d;

  logic       tick, wr_tcon;
  logic [1:0] t_edge, int_sync, tf_clr, wr_tl, wr_th, run, inc, ovf;

  // Returns {overflow, th_next, tl_next} for one increment in the given mode.
  function automatic logic [16:0] count_step(input logic [1:0] mode,
                                             input logic [7:0] th,
                                             input logic [7:0] tl);
    logic [12:0] c13;
    logic [16:0] res;
    c13 = {th, tl[4:0]} + 13'd1;
    res = {1'b0, th, tl};
    case (mode)
      2'd0:    res = {({th, tl[4:0]} == 13'h1FFF), c13[12:5], tl[7:5], c13[4:0]};
      2'd1:    res = {1'b0, th, tl} + 17'd1;
      2'd2:    res = (tl == 8'hFF) ? {1'b1, th, th} : {1'b0, th, tl + 8'd1};
      default: res = {1'b0, th, tl};
    endcase
    return res;
  endfunction

  always_comb begin
    tick     = (presc_q == PMAX);
    presc_d  = tick ? '0 : presc_q + PW'(1);

    t0_sync_d   = {t0_sync_q[1:0], T0_IN};
    t1_sync_d   = {t1_sync_q[1:0], T1_IN};
    int0_sync_d = {int0_sync_q[0], INT0_N};
    int1_sync_d = {int1_sync_q[0], INT1_N};
    // Falling edge seen between the second and third synchroniser stages.
    t_edge   = {t1_sync_q[2] & ~t1_sync_q[1], t0_sync_q[2] & ~t0_sync_q[1]};
    int_sync = {int1_sync_q[1], int0_sync_q[1]};
    tf_clr   = {TF1_CLR, TF0_CLR};

    wr_tcon = MEM_WR && (MEM_ADDR == TCON_ADDR);
    wr_tl   = {MEM_WR && (MEM_ADDR == TL1_ADDR), MEM_WR && (MEM_ADDR == TL0_ADDR)};
    wr_th   = {MEM_WR && (MEM_ADDR == TH1_ADDR), MEM_WR && (MEM_ADDR == TH0_ADDR)};
  end

  always_comb begin
    logic [16:0] step;
    logic        gate, ct, wr_cnt;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    tl_d   = tl_q;
    th_d   = th_q;
    tr_d   = tr_q;
    tf_d   = tf_q;
    tmod_d = MEM_WR && (MEM_ADDR == TMOD_ADDR) ? MEM_WR_DATA : tmod_q;
    run    = '0;
    inc    = '0;
    ovf    = '0;
    step   = '0;
    gate   = 1'b0;
    ct     = 1'b0;
    wr_cnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gate   = tmod_q[4*i+3];
      ct     = tmod_q[4*i+2];
      run[i] = tr_q[i] & (~gate | int_sync[i]);
      inc[i] = run[i] & (ct ? t_edge[i] : tick);
      step   = count_step(tmod_q[4*i +: 2], th_q[i], tl_q[i]);
      // A software write to either counter byte discards that cycle's increment.
      wr_cnt = wr_tl[i] | wr_th[i];
      ovf[i] = inc[i] & ~wr_cnt & step[16];
      if (inc[i] && !wr_cnt) {th_d[i], tl_d[i]} = step[15:0];
      if (wr_tl[i]) tl_d[i] = MEM_WR_DATA;
      if (wr_th[i]) th_d[i] = MEM_WR_DATA;
      if (tf_clr[i]) tf_d[i] = 1'b0;
      if (wr_tcon) begin
        tr_d[i] = MEM_WR_DATA[4+2*i];
        tf_d[i] = MEM_WR_DATA[5+2*i];
      end
      if (ovf[i]) tf_d[i] = 1'b1;
    end
  end

  // Unowned addresses and idle cycles return zero so the external OR-mux stays clean.
  always_comb begin
    rd_data_d = '0;
    if (MEM_RD) begin
      case (MEM_ADDR)
        TCON_ADDR: rd_data_d = {tf_q[1], tr_q[1], tf_q[0], tr_q[0], 4'b0000};
        TMOD_ADDR: rd_data_d = tmod_q;
        TL0_ADDR:  rd_data_d = tl_q[0];
        TL1_ADDR:  rd_data_d = tl_q[1];
        TH0_ADDR:  rd_data_d = th_q[0];
        TH1_ADDR:  rd_data_d = th_q[1];
        default:   rd_data_d = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tl_q        <= '0;
      th_q        <= '0;
      tr_q        <= '0;
      tf_q        <= '0;
      tmod_q      <= '0;
      rd_data_q   <= '0;
      presc_q     <= '0;
      t0_sync_q   <= '0;
      t1_sync_q   <= '0;
      int0_sync_q <= '0;
      int1_sync_q <= '0;
    end else begin
      tl_q        <= tl_d;
      th_q        <= th_d;
      tr_q        <= tr_d;
      tf_q        <= tf_d;
      tmod_q      <= tmod_d;
      rd_data_q   <= rd_data_d;
      presc_q     <= presc_d;
      t0_sync_q   <= t0_sync_d;
      t1_sync_q   <= t1_sync_d;
      int0_sync_q <= int0_sync_d;
      int1_sync_q <= int1_sync_d;
    end
  end

  assign MEM_RD_DATA = rd_data_q;
  assign TF0         = tf_q[0];
  assign TF1         = tf_q[1];

endmodule

// File: tb/tb_cpu_timer.sv
// Bench for cpu_timer: two instances (PRESCALE 12 and 1) share one SFR bus; read
// results are checked through an expected-value queue, flags are checked directly.
module tb_cpu_timer;

  localparam logic [7:0] TCON = 8'h88, TMOD = 8'h89, TL0 = 8'h8A, TL1 = 8'h8B,
                         TH0 = 8'h8C, TH1 = 8'h8D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_wr_data, mem_addr;
  logic       mem_wr, mem_rd;
  logic       t0_in, t1_in, int0_n, int1_n, tf0_clr, tf1_clr;
  logic [7:0] rd_data12, rd_data1;
  logic       tf0_12, tf1_12, tf0_1, tf1_1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    bit         sel;   // 0: PRESCALE=12 instance, 1: PRESCALE=1 instance
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  logic rd_seen = 1'b0;

  always #5 clk = ~clk;

  cpu_timer #(.PRESCALE(12)) u_dut12 (
    .CLK(clk), .RESET(rst_n), .MEM_WR_DATA(mem_wr_data), .MEM_RD_DATA(rd_data12),
    .MEM_ADDR(mem_addr), .MEM_WR(mem_wr), .MEM_RD(mem_rd),
    .T0_IN(t0_in), .T1_IN(t1_in), .INT0_N(int0_n), .INT1_N(int1_n),
    .TF0_CLR(tf0_clr), .TF1_CLR(tf1_clr), .TF0(tf0_12), .TF1(tf1_12));

  cpu_timer #(.PRESCALE(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .MEM_WR_DATA(mem_wr_data), .MEM_RD_DATA(rd_data1),
    .MEM_ADDR(mem_addr), .MEM_WR(mem_wr), .MEM_RD(mem_rd),
    .T0_IN(t0_in), .T1_IN(t1_in), .INT0_N(int0_n), .INT1_N(int1_n),
    .TF0_CLR(tf0_clr), .TF1_CLR(tf1_clr), .TF0(tf0_1), .TF1(tf1_1));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Read data is due one cycle after the strobe.
  always @(posedge clk) rd_seen <= mem_rd;

  always @(negedge clk) begin
    exp_t e;
    if (rd_seen) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        check(e.tag, e.sel ? rd_data1 : rd_data12, e.exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr      = 1'b1;
    @(negedge clk);
    mem_wr      = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [7:0] a, input logic [7:0] e, input string tag);
    exp_t x;
    x.tag = tag; x.sel = sel; x.exp = e;
    mem_addr = a;
    mem_rd   = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    mem_rd   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_t0();
    t0_in = 1'b0;
    cyc(4);
    t0_in = 1'b1;
    cyc(4);
  endtask

  initial begin
    rst_n = 1'b0; mem_wr_data = '0; mem_addr = '0; mem_wr = 1'b0; mem_rd = 1'b0;
    t0_in = 1'b1; t1_in = 1'b1; int0_n = 1'b1; int1_n = 1'b1;
    tf0_clr = 1'b0; tf1_clr = 1'b0;
    cyc(2);
    check("rst_tf0", tf0_12, 1'b0);
    check("rst_tf1", tf1_12, 1'b0);
    check("rst_rd_data", rd_data12, 8'h00);
    rst_n = 1'b1;
    cyc(1);
    rd(0, TCON, 8'h00, "rst_tcon");
    rd(0, TMOD, 8'h00, "rst_tmod");
    rd(0, TL0,  8'h00, "rst_tl0");
    rd(0, TH1,  8'h00, "rst_th1");

    // Register access
    do_reset();
    wr(TMOD, 8'h21);
    wr(TH0, 8'hAB);
    wr(8'h90, 8'h77);
    rd(0, TMOD, 8'h21, "reg_tmod");
    rd(0, TH0,  8'hAB, "reg_th0");
    rd(0, 8'h90, 8'h00, "reg_unowned");
    wr(TCON, 8'hFF);
    rd(0, TCON, 8'hF0, "reg_tcon_low_nibble");
    cyc(1);
    check("rd_idle_zero", rd_data12, 8'h00);

    // Mode 1 timer, tick every cycle
    do_reset();
    wr(TMOD, 8'h01);
    wr(TL0, 8'hFD);
    wr(TH0, 8'hFF);
    wr(TCON, 8'h10);
    rd(1, TL0, 8'hFD, "m1_tl0_fd");
    rd(1, TL0, 8'hFE, "m1_tl0_fe");
    check("m1_tf0_before", tf0_1, 1'b0);
    rd(1, TL0, 8'hFF, "m1_tl0_ff");
    check("m1_tf0_set", tf0_1, 1'b1);
    rd(1, TL0, 8'h00, "m1_tl0_00");
    rd(1, TH0, 8'h00, "m1_th0_00");
    check("m1_tf0_held", tf0_1, 1'b1);
    tf0_clr = 1'b1;
    cyc(1);
    tf0_clr = 1'b0;
    check("m1_tf0_clr", tf0_1, 1'b0);

    // Mode 0: 13-bit wrap keeps TL0[7:5]
    do_reset();
    wr(TMOD, 8'h00);
    wr(TL0, 8'hFF);
    wr(TH0, 8'hFF);
    wr(TCON, 8'h10);
    check("m0_tf0_before", tf0_1, 1'b0);
    rd(1, TL0, 8'hFF, "m0_tl0_ff");
    check("m0_tf0_set", tf0_1, 1'b1);
    rd(1, TL0, 8'hE0, "m0_tl0_wrap");
    rd(1, TH0, 8'h00, "m0_th0_wrap");

    // Mode 3: halted
    do_reset();
    wr(TMOD, 8'h03);
    wr(TL0, 8'hFF);
    wr(TH0, 8'hFF);
    wr(TCON, 8'h10);
    cyc(5);
    check("m3_tf0_never", tf0_1, 1'b0);
    rd(1, TL0, 8'hFF, "m3_tl0_hold");

    // Mode 2 auto-reload, prescale 12
    do_reset();
    wr(TMOD, 8'h20);
    wr(TH1, 8'hF0);
    wr(TL1, 8'hFE);
    wr(TCON, 8'h40);
    cyc(19);
    check("m2_tf1_before", tf1_12, 1'b0);
    rd(0, TL1, 8'hFF, "m2_tl1_ff");
    check("m2_tf1_set", tf1_12, 1'b1);
    rd(0, TL1, 8'hF0, "m2_tl1_reload");
    wr(TCON, 8'h40);
    check("m2_tf1_sw_clr", tf1_12, 1'b0);
    cyc(189);
    check("m2_tf1_not_yet", tf1_12, 1'b0);
    cyc(1);
    check("m2_tf1_reset", tf1_12, 1'b1);
    rd(0, TL1, 8'hF0, "m2_tl1_reload2");
    rd(0, TH1, 8'hF0, "m2_th1_kept");

    // Counter mode with gate
    do_reset();
    int0_n = 1'b0;
    wr(TMOD, 8'h0C);
    wr(TCON, 8'h10);
    cyc(3);
    for (int i = 0; i < 5; i++) pulse_t0();
    rd(0, TL0, 8'h00, "ctr_gated");
    int0_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 5; i++) pulse_t0();
    rd(0, TL0, 8'h05, "ctr_five");
    t0_in = 1'b0;
    cyc(2);
    rd(0, TL0, 8'h05, "ctr_lat_before");
    rd(0, TL0, 8'h06, "ctr_lat_after");
    t0_in = 1'b1;
    cyc(4);

    // Collisions: TCON write vs overflow, TF0_CLR vs overflow, TL0 write vs tick
    do_reset();
    wr(TMOD, 8'h01);
    wr(TL0, 8'hFF);
    wr(TH0, 8'hFF);
    wr(TCON, 8'h10);
    wr(TCON, 8'h10);
    check("col_tcon_set_wins", tf0_1, 1'b1);
    do_reset();
    wr(TMOD, 8'h01);
    wr(TL0, 8'hFF);
    wr(TH0, 8'hFF);
    wr(TCON, 8'h10);
    tf0_clr = 1'b1;
    cyc(1);
    tf0_clr = 1'b0;
    check("col_clr_set_wins", tf0_1, 1'b1);
    wr(TL0, 8'h55);
    rd(1, TL0, 8'h55, "col_tl0_write_wins");

    // Async reset mid-count
    do_reset();
    wr(TMOD, 8'h01);
    wr(TL0, 8'h7E);
    wr(TCON, 8'h30);
    rd(1, TCON, 8'h30, "ar_tcon_pre");
    #2 rst_n = 1'b0;
    #1;
    check("ar_tf0_now", tf0_1, 1'b0);
    check("ar_rd_data_now", rd_data1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    rd(1, TL0,  8'h00, "ar_tl0_zero");
    rd(1, TCON, 8'h00, "ar_tcon_zero");
    rd(1, TMOD, 8'h00, "ar_tmod_zero");
    wr(TCON, 8'h10);
    cyc(3);
    rd(1, TL0, 8'h03, "ar_resume");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_timer.md
Name: cpu_timer

Overview:
- 8051-style Timer0/Timer1 peripheral.
- Acts as a responder on the core's internal SFR memory bus, alongside the RAM, I/O, PC and arithmetic responders.
- Decodes TCON/TMOD/TL0/TL1/TH0/TH1 addresses and counts prescaled clock ticks or external pin edges.
- Raises overflow flags TF0/TF1 toward the interrupt logic; its read data feeds the RAM read-data mux.

Parameters:
DATA_WIDTH, 8, SFR data width (fixed 8; other values unsupported)
ADDR_WIDTH, 8, SFR address width
PRESCALE, 12, CLK cycles per timer tick in timer mode (>=1)
TCON_ADDR, 8'h88, TCON address; TMOD=+1, TL0=+2, TL1=+3, TH0=+4, TH1=+5

Ports:
CLK  in  1  single clock, all logic rising-edge
RESET  in  1  asynchronous, active-low reset
MEM_WR_DATA  in  DATA_WIDTH  write data from decoder
MEM_RD_DATA  out  DATA_WIDTH  read data to RAM read mux
MEM_ADDR  in  ADDR_WIDTH  SFR address
MEM_WR  in  1  write strobe, one cycle per access
MEM_RD  in  1  read strobe, one cycle per access
T0_IN, T1_IN  in  1 each  external count pins, asynchronous
INT0_N, INT1_N  in  1 each  gate pins, asynchronous
TF0_CLR, TF1_CLR  in  1 each  hardware flag clear from interrupt vectoring
TF0, TF1  out  1 each  overflow flags (mirror TCON bits)

Behaviour:
- Reset (RESET=0, asynchronous):
  - TCON, TMOD, TL0/1, TH0/1, prescaler, synchronisers, MEM_RD_DATA, TF0, TF1 all go to 0.
  - Release is sampled on the next CLK edge.
- Register map:
  - TCON = {TF1, TR1, TF0, TR0, 4'b0}. Bits 3:0 read 0; writes to them are ignored.
  - TMOD = {GATE1, CT1, M1_1, M0_1, GATE0, CT0, M1_0, M0_0}.
- Writes: with MEM_WR=1 and an owned address, the register updates on that CLK edge. Unowned addresses are ignored.
- Reads:
  - With MEM_RD=1 and an owned address, MEM_RD_DATA is registered. It is valid the cycle after MEM_RD and holds the pre-edge register value.
  - Otherwise MEM_RD_DATA = 0 on the next cycle, so the external OR/mux stays clean.
- Prescaler:
  - Free-running 0..PRESCALE-1, shared by both timers.
  - tick = 1 for one cycle when count == PRESCALE-1; the count then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Pin handling:
  - Tx_IN and INTx_N each pass through a 2-flop synchroniser.
  - Counter event = synchronised Tx_IN falling edge (1→0), one cycle. Total latency from pin to count is 3 cycles.
- Count enable: run_x = TRx & (~GATEx | INTx_N_sync).
- Increment strobe: inc_x = run_x & (CTx ? edge_x : tick).
- Modes, selected by {M1,M0}:
  - 0: 13-bit counter {THx, TLx[4:0]}. TLx[7:5] held. Overflow when 13'h1FFF increments to 0.
  - 1: 16-bit counter {THx, TLx}. Overflow at 16'hFFFF → 0.
  - 2: 8-bit TLx with auto-reload. On overflow of TLx=8'hFF, TLx ← THx; THx unchanged.
  - 3: counter halted and values hold; TFx is never set.
- Overflow: sets TFx on the same edge as the wrap, so TFx is visible the cycle after the final inc_x.
- Simultaneous events:
  - Software write to TLx/THx in the same cycle as inc_x: the write wins and the increment is lost. In mode 2, a TLx write wins over reload.
  - TCON write plus hardware overflow on the same edge: written value is applied, then TFx is forced to 1 (set wins).
  - TFx_CLR plus overflow on the same edge: set wins.
  - TFx_CLR alone clears TFx on the next edge.
- Mode/TR change mid-count: takes effect from the next cycle. Counter contents are not cleared.
- Reset mid-count: all state returns to 0 immediately. No pending overflow survives.
- TF0/TF1 outputs are direct register bits, with no extra latency.

Test Plan:
- Register access (PRESCALE=12): write TMOD=8'h21, TH0=8'hAB → TMOD reads 8'h21 and TH0 reads 8'hAB one cycle after MEM_RD. A read of 8'h90 returns 0. Writing TCON=8'hFF reads back 8'hF0.
- Mode 1 timer (PRESCALE=1): TMOD=8'h01, TH0:TL0=16'hFFFD, TR0=1 → TL0 goes FE, FF, 00. TF0=1 on the 3rd tick edge, TH0=8'h00. TF0_CLR pulse → TF0=0.
- Mode 2 reload (PRESCALE=12): TMOD=8'h20, TH1=8'hF0, TL1=8'hFE, TR1=1 → after 24 CLK TL1=8'hF0 and TF1=1. After 16×12 more CLK, TF1 is re-set (cleared by software in between).
- Counter plus gate: TMOD=8'h0C (CT0=1, GATE0=1, mode 0), TR0=1, INT0_N=0 → 5 T0_IN falling edges give no count. With INT0_N=1, 5 edges → TL0=5, each counted 3 cycles after its edge.
- Collision: in mode 1 at 16'hFFFF with PRESCALE=1, write TCON=8'h10 (TF0=0) in the overflow cycle → TF0=1. A separate TL0 write of 8'h55 coincident with a tick → TL0=8'h55.
- Async reset mid-count: assert RESET=0 between clock edges while TL0=8'h7F → all outputs and registers read 0 immediately; counting resumes from 0 only after RESET=1 and TR0 is written again.
